// File: rtl/counter_burst_sequencer_if.sv
// Control bundle between the burst sequencer and its requesters plus the shared counter.
// SYNC_CNT_PAUSE_EN adds the pause input to both modports.
interface counter_burst_sequencer_if #(
  parameter int unsigned CNT_W = 4
) ();
  logic [1:0]       req;
  logic [CNT_W-1:0] len0;
  logic [CNT_W-1:0] len1;
  logic [1:0]       gnt;
  logic             busy;
  logic             cnt_clear;
  logic             cnt_enable;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       done;
  logic             err;

`ifdef SYNC_CNT_PAUSE_EN
  logic             pause;

  modport master (
    input  req, len0, len1, cnt_q, pause,
    output gnt, busy, cnt_clear, cnt_enable, done, err
  );
  modport slave (
    output req, len0, len1, cnt_q, pause,
    input  gnt, busy, cnt_clear, cnt_enable, done, err
  );
`else
  modport master (
    input  req, len0, len1, cnt_q,
    output gnt, busy, cnt_clear, cnt_enable, done, err
  );
  modport slave (
    output req, len0, len1, cnt_q,
    input  gnt, busy, cnt_clear, cnt_enable, done, err
  );
`endif
endinterface

// File: rtl/counter_burst_sequencer.sv
// Round-robin sequencer sharing one external counter between two requesters.
// Optional macro SYNC_CNT_PAUSE_EN adds a pause input that stalls counting in RUN.
module counter_burst_sequencer #(
  parameter int unsigned CNT_W = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  counter_burst_sequencer_if.master  bus
);
  typedef enum logic [2:0] {StIdle, StClear, StRun, StCheck, StDone} state_e;

  state_e           state_q, state_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             clr_q, clr_d;
  logic             en_q, en_d;
  logic             err_q, err_d;
  logic             last_q, last_d;
  logic             win_q, win_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] rem_dec;
  logic [CNT_W-1:0] sel_len;
  logic             win_c;
  logic             abort;
  logic             pause_w;

`ifdef SYNC_CNT_PAUSE_EN
  assign pause_w = bus.pause;
`else
  assign pause_w = 1'b0;
`endif

  // With both requesting, the one not served last wins.
  assign win_c   = (bus.req == 2'b11) ? ~last_q : bus.req[1];
  assign sel_len = win_c ? bus.len1 : bus.len0;
  assign abort   = ~bus.req[win_q];
  // Only cycles that actually enabled the counter consume burst length.
  assign rem_dec = rem_q - {{(CNT_W-1){1'b0}}, en_q};

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    busy_d  = busy_q;
    clr_d   = 1'b0;
    en_d    = en_q;
    err_d   = err_q;
    last_d  = last_q;
    win_d   = win_q;
    len_d   = len_q;
    rem_d   = rem_q;
    case (state_q)
      StIdle: begin
        if (bus.req != 2'b00) begin
          win_d  = win_c;
          len_d  = sel_len;
          gnt_d  = win_c ? 2'b10 : 2'b01;
          busy_d = 1'b1;
          if (sel_len == '0) begin
            state_d = StDone;
            done_d  = win_c ? 2'b10 : 2'b01;
          end else begin
            state_d = StClear;
            clr_d   = 1'b1;
          end
        end
      end
      StClear: begin
        if (abort) begin
          state_d = StIdle;
          gnt_d   = '0;
          busy_d  = 1'b0;
          en_d    = 1'b0;
          last_d  = win_q;
        end else begin
          state_d = StRun;
          rem_d   = len_q;
          en_d    = 1'b1;
        end
      end
      StRun: begin
        if (abort) begin
          state_d = StIdle;
          gnt_d   = '0;
          busy_d  = 1'b0;
          en_d    = 1'b0;
          last_d  = win_q;
        end else if (rem_dec == '0) begin
          state_d = StCheck;
          en_d    = 1'b0;
        end else begin
          rem_d = rem_dec;
          en_d  = ~pause_w;
        end
      end
      StCheck: begin
        if (bus.cnt_q != len_q) begin
          err_d = 1'b1;
        end
        state_d = StDone;
        done_d  = gnt_q;
      end
      StDone: begin
        state_d = StIdle;
        gnt_d   = '0;
        busy_d  = 1'b0;
        last_d  = win_q;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      clr_q   <= 1'b0;
      en_q    <= 1'b0;
      err_q   <= 1'b0;
      last_q  <= 1'b1;
      win_q   <= 1'b0;
      len_q   <= '0;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      clr_q   <= clr_d;
      en_q    <= en_d;
      err_q   <= err_d;
      last_q  <= last_d;
      win_q   <= win_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
    end
  end

  assign bus.gnt        = gnt_q;
  assign bus.done       = done_q;
  assign bus.busy       = busy_q;
  assign bus.cnt_clear  = clr_q;
  assign bus.cnt_enable = en_q;
  assign bus.err        = err_q;
endmodule

// File: tb/tb_counter_burst_sequencer.sv
// Directed bench for counter_burst_sequencer with a model of the shared 4-bit counter.
// Pause scenario is built only when SYNC_CNT_PAUSE_EN is defined.
module tb_counter_burst_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] cnt_model = 4'd0;
  logic [3:0] force_val = 4'd0;
  logic       force_en  = 1'b0;

  counter_burst_sequencer_if #(.CNT_W(4)) bus ();

  counter_burst_sequencer #(.CNT_W(4)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  // External sync_counter: synchronous clear, count when enabled.
  always @(posedge clk) begin
    if (bus.cnt_clear) cnt_model <= 4'd0;
    else if (bus.cnt_enable) cnt_model <= cnt_model + 4'd1;
  end
  assign bus.cnt_q = force_en ? force_val : cnt_model;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    bus.req = 2'b00;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    bus.req  = 2'b01;
    bus.len0 = 4'd5;
    tick();
    tick();
    checks++;
    if ({bus.gnt, bus.busy, bus.cnt_clear, bus.cnt_enable, bus.done} !== 7'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b want 0000000",
               {bus.gnt, bus.busy, bus.cnt_clear, bus.cnt_enable, bus.done});
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %b want 0", bus.err);
    end
    bus.req = 2'b00;
    reset   = 1'b0;
    tick();
  endtask

  task automatic test_single_burst();
    logic [1:0] g1, done_v;
    logic       c1, busy9;
    logic [3:0] q7;
    int         clr_n, en_n, done_k;
    clr_n = 0; en_n = 0; done_k = 0; done_v = 2'b00; busy9 = 1'b1;
    g1 = 2'b00; c1 = 1'b0; q7 = 4'd0;
    bus.req  = 2'b01;
    bus.len0 = 4'd5;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 1) begin g1 = bus.gnt; c1 = bus.cnt_clear; end
      if (k == 7) q7 = bus.cnt_q;
      if (k == 9) busy9 = bus.busy;
      if (bus.cnt_clear) clr_n++;
      if (bus.cnt_enable) en_n++;
      if (bus.done != 2'b00) begin done_k = k; done_v = bus.done; end
      if (k == 2) bus.len0 = 4'd2;
      if (k == 8) bus.req = 2'b00;
    end
    checks++;
    if (g1 !== 2'b01) begin errors++; $display("FAIL single_gnt got %b want 01", g1); end
    checks++;
    if (c1 !== 1'b1) begin errors++; $display("FAIL single_clear_at_grant got %b want 1", c1); end
    checks++;
    if (clr_n !== 1) begin errors++; $display("FAIL single_clear_cycles got %0d want 1", clr_n); end
    checks++;
    if (en_n !== 5) begin errors++; $display("FAIL single_en_cycles got %0d want 5", en_n); end
    checks++;
    if (q7 !== 4'd5) begin errors++; $display("FAIL single_cnt_at_check got %0d want 5", q7); end
    checks++;
    if (done_k !== 8) begin errors++; $display("FAIL single_done_cycle got %0d want 8", done_k); end
    checks++;
    if (done_v !== 2'b01) begin errors++; $display("FAIL single_done_val got %b want 01", done_v); end
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL single_err got %b want 0", bus.err); end
    checks++;
    if (busy9 !== 1'b0) begin errors++; $display("FAIL single_busy_after got %b want 0", busy9); end
    bus.len0 = 4'd0;
  endtask

  task automatic test_round_robin();
    int         dk[3];
    logic [1:0] dv[3];
    int         exp_k[3];
    logic [1:0] exp_v[3];
    int         nd;
    logic       both;
    logic [1:0] g1;
    logic [3:0] q5, q13;
    exp_k[0] = 6;  exp_k[1] = 14;    exp_k[2] = 21;
    exp_v[0] = 2'b01; exp_v[1] = 2'b10; exp_v[2] = 2'b01;
    for (int i = 0; i < 3; i++) begin dk[i] = 0; dv[i] = 2'b00; end
    nd = 0; both = 1'b0; g1 = 2'b00; q5 = 4'd0; q13 = 4'd0;
    do_reset();
    bus.req  = 2'b11;
    bus.len0 = 4'd3;
    bus.len1 = 4'd4;
    for (int k = 1; k <= 23; k++) begin
      tick();
      if (k == 1) g1 = bus.gnt;
      if (k == 5) q5 = bus.cnt_q;
      if (k == 13) q13 = bus.cnt_q;
      if (bus.gnt == 2'b11) both = 1'b1;
      if (bus.done != 2'b00 && nd < 3) begin dk[nd] = k; dv[nd] = bus.done; nd++; end
      if (k == 21) bus.req = 2'b00;
    end
    checks++;
    if (g1 !== 2'b01) begin errors++; $display("FAIL rr_first_gnt got %b want 01", g1); end
    checks++;
    if (nd !== 3) begin errors++; $display("FAIL rr_done_count got %0d want 3", nd); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (dk[i] !== exp_k[i] || dv[i] !== exp_v[i]) begin
        errors++;
        $display("FAIL rr_done_%0d got cycle %0d val %b want cycle %0d val %b",
                 i, dk[i], dv[i], exp_k[i], exp_v[i]);
      end
    end
    checks++;
    if (q5 !== 4'd3) begin errors++; $display("FAIL rr_cnt_req0 got %0d want 3", q5); end
    checks++;
    if (q13 !== 4'd4) begin errors++; $display("FAIL rr_cnt_req1 got %0d want 4", q13); end
    checks++;
    if (both !== 1'b0) begin errors++; $display("FAIL rr_gnt_onehot got %b want 0", both); end
  endtask

  task automatic test_zero_len();
    logic [1:0] g1, d1;
    logic       busy2;
    int         clr_n, en_n;
    clr_n = 0; en_n = 0; g1 = 2'b00; d1 = 2'b00; busy2 = 1'b1;
    bus.req  = 2'b01;
    bus.len0 = 4'd0;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 1) begin g1 = bus.gnt; d1 = bus.done; bus.req = 2'b00; end
      if (k == 2) busy2 = bus.busy;
      if (bus.cnt_clear) clr_n++;
      if (bus.cnt_enable) en_n++;
    end
    checks++;
    if (g1 !== 2'b01) begin errors++; $display("FAIL zero_gnt got %b want 01", g1); end
    checks++;
    if (d1 !== 2'b01) begin errors++; $display("FAIL zero_done got %b want 01", d1); end
    checks++;
    if (clr_n !== 0) begin errors++; $display("FAIL zero_clear_cycles got %0d want 0", clr_n); end
    checks++;
    if (en_n !== 0) begin errors++; $display("FAIL zero_en_cycles got %0d want 0", en_n); end
    checks++;
    if (busy2 !== 1'b0) begin errors++; $display("FAIL zero_busy_after got %b want 0", busy2); end
  endtask

  task automatic test_max_len_err();
    int         en_n, done_k;
    logic [3:0] q17;
    logic       err6;
    en_n = 0; done_k = 0; q17 = 4'd0; err6 = 1'b0;
    bus.req  = 2'b10;
    bus.len1 = 4'd15;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (k == 17) q17 = bus.cnt_q;
      if (bus.cnt_enable) en_n++;
      if (bus.done == 2'b10) done_k = k;
      if (k == 18) bus.req = 2'b00;
    end
    checks++;
    if (en_n !== 15) begin errors++; $display("FAIL max_en_cycles got %0d want 15", en_n); end
    checks++;
    if (q17 !== 4'd15) begin errors++; $display("FAIL max_cnt_at_check got %0d want 15", q17); end
    checks++;
    if (done_k !== 18) begin errors++; $display("FAIL max_done_cycle got %0d want 18", done_k); end
    checks++;
    if (bus.err !== 1'b0) begin errors++; $display("FAIL max_err got %b want 0", bus.err); end
    // Next burst: corrupt the counter value seen at CHECK.
    bus.req  = 2'b10;
    bus.len1 = 4'd3;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 5) begin force_val = 4'd7; force_en = 1'b1; end
      if (k == 6) begin err6 = bus.err; force_en = 1'b0; bus.req = 2'b00; end
    end
    checks++;
    if (err6 !== 1'b1) begin errors++; $display("FAIL err_set got %b want 1", err6); end
    // A clean burst afterwards must not clear the sticky error.
    bus.req  = 2'b01;
    bus.len0 = 4'd2;
    for (int k = 1; k <= 7; k++) begin
      tick();
      if (k == 5) bus.req = 2'b00;
    end
    checks++;
    if (bus.err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", bus.err); end
    // Reset in the middle of a burst.
    bus.req  = 2'b01;
    bus.len0 = 4'd10;
    for (int k = 1; k <= 4; k++) tick();
    reset = 1'b1;
    tick();
    checks++;
    if ({bus.gnt, bus.busy, bus.cnt_clear, bus.cnt_enable, bus.done, bus.err} !== 8'd0) begin
      errors++;
      $display("FAIL midreset_outputs got %b want 00000000",
               {bus.gnt, bus.busy, bus.cnt_clear, bus.cnt_enable, bus.done, bus.err});
    end
    bus.req = 2'b00;
    reset   = 1'b0;
    tick();
  endtask

  task automatic test_abort();
    int         en_n;
    logic       en6, busy6, any_done;
    logic [1:0] gnt6, g9;
    en_n = 0; en6 = 1'b1; busy6 = 1'b1; gnt6 = 2'b11; any_done = 1'b0; g9 = 2'b00;
    do_reset();
    bus.req  = 2'b01;
    bus.len0 = 4'd10;
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 6) begin en6 = bus.cnt_enable; busy6 = bus.busy; gnt6 = bus.gnt; end
      if (bus.cnt_enable) en_n++;
      if (bus.done != 2'b00) any_done = 1'b1;
      if (k == 5) bus.req = 2'b00;
    end
    bus.req  = 2'b11;
    bus.len1 = 4'd4;
    tick();
    g9 = bus.gnt;
    bus.req = 2'b00;
    tick();
    checks++;
    if (en_n !== 4) begin errors++; $display("FAIL abort_en_cycles got %0d want 4", en_n); end
    checks++;
    if (en6 !== 1'b0) begin errors++; $display("FAIL abort_en_low got %b want 0", en6); end
    checks++;
    if (busy6 !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy6); end
    checks++;
    if (gnt6 !== 2'b00) begin errors++; $display("FAIL abort_gnt got %b want 00", gnt6); end
    checks++;
    if (any_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %b want 0", any_done); end
    checks++;
    if (g9 !== 2'b10) begin errors++; $display("FAIL abort_next_gnt got %b want 10", g9); end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_in_clear_busy got %b want 0", bus.busy);
    end
  endtask

`ifdef SYNC_CNT_PAUSE_EN
  task automatic test_pause();
    int         en_n, done_k;
    logic [3:0] q11;
    en_n = 0; done_k = 0; q11 = 4'd0;
    do_reset();
    bus.req  = 2'b01;
    bus.len0 = 4'd6;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == 11) q11 = bus.cnt_q;
      if (bus.cnt_enable) en_n++;
      if (bus.done == 2'b01) done_k = k;
      if (k == 2) bus.pause = 1'b1;
      if (k == 5) bus.pause = 1'b0;
      if (k == 12) bus.req = 2'b00;
    end
    checks++;
    if (en_n !== 6) begin errors++; $display("FAIL pause_en_cycles got %0d want 6", en_n); end
    checks++;
    if (done_k !== 12) begin errors++; $display("FAIL pause_done_cycle got %0d want 12", done_k); end
    checks++;
    if (q11 !== 4'd6) begin errors++; $display("FAIL pause_cnt_at_check got %0d want 6", q11); end
  endtask
`endif

  initial begin
    reset    = 1'b1;
    bus.req  = 2'b00;
    bus.len0 = 4'd0;
    bus.len1 = 4'd0;
`ifdef SYNC_CNT_PAUSE_EN
    bus.pause = 1'b0;
`endif
    test_reset();
    test_single_burst();
    test_round_robin();
    test_zero_len();
    test_max_len_err();
    test_abort();
`ifdef SYNC_CNT_PAUSE_EN
    test_pause();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/counter_burst_sequencer.md
Name: counter_burst_sequencer

Overview:
- Sequencer that shares one external 4-bit `sync_counter` (ports `clk`/`reset`/`enable`/`q`) between two requesters.
- Arbitrates round-robin and clears the counter through its synchronous reset.
- Enables the counter for exactly the granted requester's burst length, then checks `q` against that length.
- Reports per-requester completion and a sticky mismatch error; sits beside the counter and drives its control pins.

Parameters:
- CNT_W, 4, width of counter value `cnt_q` and of the burst lengths.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- req  input  2  level request per requester; bit i = requester i.
- len0  input  CNT_W  burst length for requester 0; sampled at grant.
- len1  input  CNT_W  burst length for requester 1; sampled at grant.
- gnt  output  2  one-hot grant, held from CLEAR through DONE.
- busy  output  1  high in any state other than IDLE.
- cnt_clear  output  1  drives counter `reset`; one-cycle pulse.
- cnt_enable  output  1  drives counter `enable`.
- cnt_q  input  CNT_W  counter output `q`.
- done  output  2  one-cycle completion pulse per requester.
- err  output  1  sticky: counter value mismatched the burst length at CHECK.

Behaviour:
- All outputs are registered.
- Reset values: gnt=0, busy=0, cnt_clear=0, cnt_enable=0, done=0, err=0, state=IDLE, last_gnt=1 (so requester 0 wins first).
- IDLE:
  - If req!=0, pick the winner: if both bits are set, the requester not in last_gnt wins; otherwise the single one.
  - Latch the winner's len into len_r and the winner index.
  - Next cycle: state CLEAR, gnt set.
- len_r==0 at grant: go directly to DONE; no cnt_clear, no cnt_enable.
- CLEAR (1 cycle):
  - cnt_clear=1, cnt_enable=0.
  - The counter reads 0 after this edge.
  - Load remaining = len_r.
- RUN:
  - cnt_enable=1; remaining decrements each cycle.
  - Lasts exactly len_r cycles; cnt_enable drops in the cycle after the last enable.
  - Next state CHECK.
- CHECK (1 cycle):
  - cnt_enable=0.
  - If cnt_q != len_r, set err (sticky; cleared only by reset).
- DONE (1 cycle):
  - done[winner]=1; gnt still asserted.
  - last_gnt = winner; next state IDLE with gnt=0.
- Latency: grant to done pulse = len_r+3 cycles (CLEAR + len_r RUN + CHECK + DONE) for len_r>0; 1 cycle for len_r=0.
- Back-to-back: IDLE occupies at least one cycle between bursts; a request held through DONE is re-arbitrated in that IDLE cycle.
- Abort: if req[winner] deasserts in CLEAR or RUN:
  - Next cycle cnt_enable=0 and state IDLE; no done, no CHECK.
  - last_gnt is still updated to winner.
- Deassertion of req in CHECK/DONE is ignored; the burst completes normally.
- len0/len1 changes after the grant are ignored.
- req bits of the non-granted requester are ignored while busy.
- Max burst is 2^CNT_W-1 = 15, so the counter never wraps within a burst.
- Reset mid-operation: all outputs return to reset values on the next edge; no done pulse is emitted.

Optional Feature:
- Macro SYNC_CNT_PAUSE_EN.
- Defined:
  - Adds input `pause` (1 bit).
  - While pause=1 in RUN: cnt_enable=0 and remaining is held; counting resumes when pause=0.
  - Latency grows by the number of paused RUN cycles.
  - pause is ignored in other states.
  - Abort via req drop still works while paused.
- Not defined: no `pause` port; RUN is exactly len_r consecutive enable cycles.

Test Plan:
- Reset held 2 cycles, then req=01, len0=5: gnt=01 next cycle, cnt_clear pulse 1 cycle, cnt_enable high 5 cycles, cnt_q=5 at CHECK, done=01 at grant+8, err=0.
- req=11 held, len0=3, len1=4: requester 0 served first (done=01), then requester 1 (done=10, cnt_q=4), then requester 0 again; gnt never both high.
- req=01, len0=0: done=01 one cycle after grant; cnt_clear and cnt_enable never asserted.
- req=10, len1=15: 15 enable cycles, cnt_q=15 at CHECK, no wrap, err=0. Then force cnt_q=7 in the bench at CHECK of the next burst: err=1 and stays 1 until reset.
- req=01, len0=10, drop req after 4 RUN cycles: cnt_enable low next cycle, no done, busy=0; next req=11 grants requester 1.
- With SYNC_CNT_PAUSE_EN, len0=6, pause=1 for 3 RUN cycles: exactly 6 enable cycles total, done at grant+12, cnt_q=6.
